// File: rtl/h_ecc_pkg.sv
// Shared ECC definitions: codeword/data widths, response status encoding
// and the clean/corrected/uncorrectable classification rule.
package h_ecc_pkg;

    localparam int CW_W = 12;   // 11-bit Hamming word plus overall parity in bit 0
    localparam int DW_W = 7;

    typedef enum logic [1:0] {
        ST_CLEAN  = 2'b00,
        ST_CORR   = 2'b01,
        ST_UNCORR = 2'b10
    } ecc_status_t;

    typedef struct packed {
        logic [DW_W-1:0] data;
        ecc_status_t     status;
    } ecc_rsp_t;

    // Any odd overall parity is treated as a single-bit error (correctable);
    // even parity with a non-zero syndrome means two bits flipped.
    function automatic ecc_status_t classify(input logic [3:0] syn, input logic par);
        ecc_status_t st;
        if (par)
            st = ST_CORR;
        else if (syn != 4'd0)
            st = ST_UNCORR;
        else
            st = ST_CLEAN;
        return st;
    endfunction

endpackage

// File: rtl/h_decoder_11_7.sv
// Hamming(11,7) decoder. i_Code[p-1] holds codeword position p (1..11);
// parity bits sit at positions 1,2,4,8, data at 3,5,6,7,9,10,11 (LSB first).
// Computes the syndrome and flips the addressed position before extracting data.
module h_decoder_11_7 (
    input  logic [10:0] i_Code,
    output logic [6:0]  o_Data,
    output logic [3:0]  o_Syndrome
);

    logic [11:1] pos;
    logic [11:1] flip;
    logic [11:1] fixed;

    assign pos = i_Code;

    assign o_Syndrome[0] = pos[1] ^ pos[3] ^ pos[5] ^ pos[7] ^ pos[9]  ^ pos[11];
    assign o_Syndrome[1] = pos[2] ^ pos[3] ^ pos[6] ^ pos[7] ^ pos[10] ^ pos[11];
    assign o_Syndrome[2] = pos[4] ^ pos[5] ^ pos[6] ^ pos[7];
    assign o_Syndrome[3] = pos[8] ^ pos[9] ^ pos[10] ^ pos[11];

    // One-hot flip mask; syndromes 0 and 12..15 point nowhere and flip nothing.
    always_comb begin
        flip = '0;
        for (int p = 1; p <= 11; p++)
            flip[p] = (o_Syndrome == 4'(p));
    end

    assign fixed  = pos ^ flip;
    assign o_Data = {fixed[11], fixed[10], fixed[9], fixed[7], fixed[6], fixed[5], fixed[3]};

endmodule

// File: rtl/h_rr_pick.sv
// Round-robin pick: first set request at or above i_Ptr, wrapping to 0.
module h_rr_pick #(
    parameter  int NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_Req,
    input  logic [ID_W-1:0] i_Ptr,
    output logic [NREQ-1:0] o_Gnt,
    output logic [ID_W-1:0] o_Idx,
    output logic            o_Any
);

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        int              cand;
        logic [ID_W-1:0] cidx;
        cand  = 0;
        cidx  = '0;
        o_Gnt = '0;
        o_Idx = '0;
        o_Any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = int'(i_Ptr) + i;
            if (cand >= NREQ)
                cand = cand - NREQ;
            cidx = ID_W'(cand);
            if (i_Req[cidx]) begin
                o_Idx = cidx;
                o_Any = 1'b1;
            end
        end
        o_Gnt[o_Idx] = o_Any;
    end

endmodule

// File: rtl/h_decode_arbiter.sv
// Shares one Hamming(11,7) decoder between NREQ codeword requesters.
// Grant, mux, decode and classify are combinational in the grant cycle;
// the response, event counters and sticky IRQ register on the same edge.
module h_decode_arbiter
    import h_ecc_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int CNT_W = 16,
    localparam int ID_W  = $clog2(NREQ)
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    input  logic [NREQ-1:0]      i_ReqValid,
    input  logic [NREQ*CW_W-1:0] i_ReqCode,
    output logic [NREQ-1:0]      o_ReqReady,
    output logic                 o_RspValid,
    input  logic                 i_RspReady,
    output logic [DW_W-1:0]      o_RspData,
    output logic [ID_W-1:0]      o_RspId,
    output logic [1:0]           o_RspStatus,
    output logic [CNT_W-1:0]     o_CorrCnt,
    output logic [CNT_W-1:0]     o_UncorrCnt,
    input  logic                 i_CntClr,
    output logic                 o_Irq,
    input  logic                 i_IrqClr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ID_W-1:0] rr_ptr;
    logic [NREQ-1:0] gnt;
    logic [ID_W-1:0] gnt_idx;
    logic            gnt_any;
    logic            can_acc;
    logic            xfer;
    logic [CW_W-1:0] sel_code;
    logic [3:0]      dec_syn;
    logic            par;
    ecc_rsp_t        rsp_nxt;
    logic            inc_corr;
    logic            inc_unc;

    h_rr_pick #(.NREQ(NREQ)) u_pick (
        .i_Req (i_ReqValid),
        .i_Ptr (rr_ptr),
        .o_Gnt (gnt),
        .o_Idx (gnt_idx),
        .o_Any (gnt_any)
    );

    // Grant is offered only when the response slot is free or draining.
    assign can_acc    = !o_RspValid || i_RspReady;
    assign o_ReqReady = can_acc ? gnt : '0;
    assign xfer       = can_acc && gnt_any;

    assign sel_code = i_ReqCode[gnt_idx*CW_W +: CW_W];

    h_decoder_11_7 u_dec (
        .i_Code     (sel_code[CW_W-1:1]),
        .o_Data     (rsp_nxt.data),
        .o_Syndrome (dec_syn)
    );

    // Overall parity covers all 12 bits, including the parity bit itself.
    assign par            = ^sel_code;
    assign rsp_nxt.status = classify(dec_syn, par);
    assign inc_corr       = xfer && (rsp_nxt.status == ST_CORR);
    assign inc_unc        = xfer && (rsp_nxt.status == ST_UNCORR);

    // Round-robin pointer moves just past the requester that transferred.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n)
            rr_ptr <= '0;
        else if (xfer)
            rr_ptr <= (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // Response register: load on transfer, drop valid once consumed, else hold.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_RspValid  <= 1'b0;
            o_RspData   <= '0;
            o_RspId     <= '0;
            o_RspStatus <= '0;
        end else if (xfer) begin
            o_RspValid  <= 1'b1;
            o_RspData   <= rsp_nxt.data;
            o_RspId     <= gnt_idx;
            o_RspStatus <= rsp_nxt.status;
        end else if (i_RspReady) begin
            o_RspValid  <= 1'b0;
        end
    end

    // Corrected counter: saturating; a clear with a coincident hit counts that hit.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n)
            o_CorrCnt <= '0;
        else if (i_CntClr)
            o_CorrCnt <= inc_corr ? CNT_W'(1) : '0;
        else if (inc_corr && o_CorrCnt != CNT_MAX)
            o_CorrCnt <= o_CorrCnt + 1'b1;
    end

    // Uncorrectable counter: same rules as the corrected counter.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n)
            o_UncorrCnt <= '0;
        else if (i_CntClr)
            o_UncorrCnt <= inc_unc ? CNT_W'(1) : '0;
        else if (inc_unc && o_UncorrCnt != CNT_MAX)
            o_UncorrCnt <= o_UncorrCnt + 1'b1;
    end

    // Sticky IRQ: a new uncorrectable event beats a simultaneous clear.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n)
            o_Irq <= 1'b0;
        else if (inc_unc)
            o_Irq <= 1'b1;
        else if (i_IrqClr)
            o_Irq <= 1'b0;
    end

endmodule

// File: tb/tb_h_decode_arbiter.sv
// Randomized + directed bench for h_decode_arbiter with a transaction-level
// reference model (grant search, syndrome by XOR of set positions, counters).
module tb_h_decode_arbiter;

    localparam int NREQ  = 4;
    localparam int CNT_W = 2;
    localparam int ID_W  = 2;
    localparam int CMAX  = 3;
    localparam int DPOS[7] = '{3, 5, 6, 7, 9, 10, 11};

    logic                 i_Clk;
    logic                 i_Rst_n;
    logic [NREQ-1:0]      i_ReqValid;
    logic [NREQ*12-1:0]   i_ReqCode;
    logic [NREQ-1:0]      o_ReqReady;
    logic                 o_RspValid;
    logic                 i_RspReady;
    logic [6:0]           o_RspData;
    logic [ID_W-1:0]      o_RspId;
    logic [1:0]           o_RspStatus;
    logic [CNT_W-1:0]     o_CorrCnt;
    logic [CNT_W-1:0]     o_UncorrCnt;
    logic                 i_CntClr;
    logic                 o_Irq;
    logic                 i_IrqClr;

    h_decode_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
        .i_Clk       (i_Clk),
        .i_Rst_n     (i_Rst_n),
        .i_ReqValid  (i_ReqValid),
        .i_ReqCode   (i_ReqCode),
        .o_ReqReady  (o_ReqReady),
        .o_RspValid  (o_RspValid),
        .i_RspReady  (i_RspReady),
        .o_RspData   (o_RspData),
        .o_RspId     (o_RspId),
        .o_RspStatus (o_RspStatus),
        .o_CorrCnt   (o_CorrCnt),
        .o_UncorrCnt (o_UncorrCnt),
        .i_CntClr    (i_CntClr),
        .o_Irq       (o_Irq),
        .i_IrqClr    (i_IrqClr)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    int n_chk;
    int n_fail;

    // reference model state
    int         m_ptr;
    bit         m_vld;
    logic [6:0] m_data;
    int         m_id;
    logic [1:0] m_st;
    int         m_corr;
    int         m_unc;
    bit         m_irq;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_ptr = 0; m_vld = 0; m_data = '0; m_id = 0; m_st = '0;
        m_corr = 0; m_unc = 0; m_irq = 0;
    endtask

    // Encode 7 data bits: syndrome of data-only word gives the parity bits.
    function automatic logic [11:0] enc(input logic [6:0] d);
        logic [11:0] c;
        int s;
        c = '0;
        s = 0;
        for (int k = 0; k < 7; k++) c[DPOS[k]] = d[k];
        for (int p = 1; p <= 11; p++) if (c[p]) s = s ^ p;
        c[1] = s[0]; c[2] = s[1]; c[4] = s[2]; c[8] = s[3];
        c[0] = ^c[11:1];
        return c;
    endfunction

    task automatic mdec(input logic [11:0] cw, output logic [6:0] d, output logic [1:0] st);
        logic [11:0] c;
        int s;
        c = cw;
        s = 0;
        for (int p = 1; p <= 11; p++) if (cw[p]) s = s ^ p;
        if (^cw)        st = 2'b01;
        else if (s != 0) st = 2'b10;
        else            st = 2'b00;
        if (s >= 1 && s <= 11) c[s] = ~c[s];
        for (int k = 0; k < 7; k++) d[k] = c[DPOS[k]];
    endtask

    function automatic logic [NREQ*12-1:0] one(input int k, input logic [11:0] cw);
        logic [NREQ*12-1:0] v;
        v = '0;
        v[k*12 +: 12] = cw;
        return v;
    endfunction

    function automatic logic [NREQ*12-1:0] rnd_codes(input bit valid_only);
        logic [NREQ*12-1:0] v;
        for (int k = 0; k < NREQ; k++)
            v[k*12 +: 12] = valid_only ? enc(7'($urandom)) : 12'($urandom);
        return v;
    endfunction

    task automatic chk_outs(input string ph);
        chk({ph, ".rsp_valid"}, 32'(o_RspValid), 32'(m_vld));
        chk({ph, ".rsp_data"}, 32'(o_RspData), 32'(m_data));
        chk({ph, ".rsp_id"}, 32'(o_RspId), 32'(m_id));
        chk({ph, ".rsp_status"}, 32'(o_RspStatus), 32'(m_st));
        chk({ph, ".corr_cnt"}, 32'(o_CorrCnt), 32'(m_corr));
        chk({ph, ".uncorr_cnt"}, 32'(o_UncorrCnt), 32'(m_unc));
        chk({ph, ".irq"}, 32'(o_Irq), 32'(m_irq));
    endtask

    // One cycle: drive just after the edge, check ready mid-cycle,
    // advance the model, check registered outputs just after the next edge.
    task automatic step(input string ph, input logic [NREQ-1:0] v, input logic [NREQ*12-1:0] c,
                        input logic rr, input logic cc, input logic ic);
        bit         can, found, xfer;
        int         g, idx;
        logic [3:0] exp_rdy;
        logic [6:0] d;
        logic [1:0] st;
        i_ReqValid = v; i_ReqCode = c; i_RspReady = rr; i_CntClr = cc; i_IrqClr = ic;
        #2;
        can = !m_vld || rr;
        found = 0;
        g = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (!found && v[idx]) begin found = 1; g = idx; end
        end
        xfer = can && found;
        exp_rdy = xfer ? (4'b0001 << g) : 4'b0000;
        chk({ph, ".req_ready"}, 32'(o_ReqReady), 32'(exp_rdy));
        mdec(c[g*12 +: 12], d, st);
        if (xfer) begin
            m_vld = 1; m_data = d; m_id = g; m_st = st;
            m_ptr = (g + 1) % NREQ;
        end else if (rr) begin
            m_vld = 0;
        end
        if (cc) m_corr = (xfer && st == 2'b01) ? 1 : 0;
        else if (xfer && st == 2'b01 && m_corr < CMAX) m_corr++;
        if (cc) m_unc = (xfer && st == 2'b10) ? 1 : 0;
        else if (xfer && st == 2'b10 && m_unc < CMAX) m_unc++;
        if (xfer && st == 2'b10) m_irq = 1;
        else if (ic) m_irq = 0;
        @(posedge i_Clk);
        #1;
        chk_outs(ph);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        i_Rst_n = 1'b0;
        i_ReqValid = '0; i_ReqCode = '0; i_RspReady = 1'b0; i_CntClr = 1'b0; i_IrqClr = 1'b0;
        m_reset();
        #12;
        chk_outs("reset");
        chk("reset.req_ready", 32'(o_ReqReady), 32'd0);
        i_Rst_n = 1'b1;
        @(posedge i_Clk);
        #1;

        // fairness from reset: expect ids 0,1,2,3,0,1
        for (int i = 0; i < 6; i++) begin
            step("fair", 4'hF, rnd_codes(1), 1'b1, 1'b0, 1'b0);
            chk("fair.id_seq", 32'(o_RspId), 32'(i % NREQ));
        end

        // clean word from requester 2
        step("clean", 4'b0100, one(2, 12'h000), 1'b1, 1'b0, 1'b0);

        // backpressure: response held, nothing granted
        for (int i = 0; i < 5; i++)
            step("bp", 4'hF, rnd_codes(1), 1'b0, 1'b0, 1'b0);
        step("bp_release", 4'hF, rnd_codes(1), 1'b1, 1'b0, 1'b0);

        // error classes and IRQ set-over-clear
        step("corr", 4'b0010, one(1, 12'h001), 1'b1, 1'b0, 1'b0);
        step("uncorr", 4'b0010, one(1, 12'h009), 1'b1, 1'b0, 1'b0);
        step("irq_set_wins", 4'b0010, one(1, 12'h009), 1'b1, 1'b0, 1'b1);
        step("irq_clr", 4'b0000, '0, 1'b1, 1'b0, 1'b1);

        // counter saturation and clear-with-increment
        for (int i = 0; i < 5; i++)
            step("sat", 4'b0001, one(0, 12'h001), 1'b1, 1'b0, 1'b0);
        chk("sat.corr_max", 32'(o_CorrCnt), 32'(CMAX));
        step("clr_inc", 4'b0001, one(0, 12'h001), 1'b1, 1'b1, 1'b0);
        step("clr_only", 4'b0000, '0, 1'b1, 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 400; i++)
            step("rnd", NREQ'($urandom), rnd_codes($urandom_range(0, 1) == 0),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 15) == 0);

        // reset with a pending response; it must be dropped
        step("pre_rst", 4'hF, one(3, 12'h009), 1'b1, 1'b0, 1'b0);
        step("pre_rst_hold", 4'b0000, '0, 1'b0, 1'b0, 1'b0);
        #2;
        i_Rst_n = 1'b0;
        #1;
        m_reset();
        chk_outs("mid_rst");
        chk("mid_rst.req_ready", 32'(o_ReqReady), 32'd0);
        #2;
        i_Rst_n = 1'b1;
        @(posedge i_Clk);
        #1;
        chk_outs("post_rst");
        step("post_rst_grant", 4'hF, rnd_codes(1), 1'b1, 1'b0, 1'b0);
        chk("post_rst.first_id", 32'(o_RspId), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
